// File: rtl/multi_debouncer_pkg.sv
// Shared constants for the multi-channel debouncer: default counter width,
// synchroniser depth and the terminal-count helper.
package multi_debouncer_pkg;

    localparam int unsigned DEBOUNCE_CNT_WIDTH_DEF = 2;
    localparam int unsigned SYNC_DEPTH             = 2;

    // Last counter value before a commit: 2**width - 1.
    function automatic int unsigned term_count(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: stability counter, commit of the filtered level and
// registered one-cycle rise/fall strobes.
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned p_CNT_WIDTH  = DEBOUNCE_CNT_WIDTH_DEF,
    parameter logic        p_INIT_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [p_CNT_WIDTH-1:0] TERM = p_CNT_WIDTH'(term_count(p_CNT_WIDTH));

    logic [p_CNT_WIDTH-1:0] cnt;

    // The terminal value always commits or clears, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= p_INIT_VALUE;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                level <= sample;
                cnt   <= '0;
                rise  <= sample;
                fall  <= ~sample;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// Parametrised multi-channel debouncer top. Optional input synchroniser is
// enabled with the MULTI_DEBOUNCER_SYNC_EN macro.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned          p_CH_CNT     = 4,
    parameter int unsigned          p_CNT_WIDTH  = DEBOUNCE_CNT_WIDTH_DEF,
    parameter logic [p_CH_CNT-1:0]  p_INIT_VALUE = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [p_CH_CNT-1:0] i_in,
    output logic [p_CH_CNT-1:0] o_out,
    output logic [p_CH_CNT-1:0] o_rise,
    output logic [p_CH_CNT-1:0] o_fall,
    output logic                o_changed
);

    logic [p_CH_CNT-1:0] sample;

`ifdef MULTI_DEBOUNCER_SYNC_EN
    logic [p_CH_CNT-1:0] sync_q [SYNC_DEPTH];

    // Reset to the initial level so release does not start a spurious count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= p_INIT_VALUE;
            end
        end else begin
            sync_q[0] <= i_in;
            for (int unsigned i = 1; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sample = sync_q[SYNC_DEPTH-1];
`else
    assign sample = i_in;
`endif

    for (genvar k = 0; k < p_CH_CNT; k++) begin : g_ch
        debounce_channel #(
            .p_CNT_WIDTH  (p_CNT_WIDTH),
            .p_INIT_VALUE (p_INIT_VALUE[k])
        ) u_ch (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .sample (sample[k]),
            .level  (o_out[k]),
            .rise   (o_rise[k]),
            .fall   (o_fall[k])
        );
    end

    assign o_changed = |(o_rise | o_fall);

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: a behavioural reference model
// pushes per-cycle expectations to a scoreboard queue that is popped after each edge.
module tb_multi_debouncer;

    localparam int unsigned CH     = 4;
    localparam int unsigned W      = 2;
    localparam logic [CH-1:0] INIT = 4'b0000;
    localparam int unsigned PERIOD = 1 << W;
`ifdef MULTI_DEBOUNCER_SYNC_EN
    localparam int unsigned LAT = PERIOD + 2;
`else
    localparam int unsigned LAT = PERIOD;
`endif

    typedef struct packed {
        logic [CH-1:0] out;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          changed;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] din;
    logic [CH-1:0] o_out, o_rise, o_fall;
    logic          o_changed;

    int unsigned passes = 0;
    int unsigned checks = 0;

    exp_t        sb[$];
    logic [CH-1:0] m_out, m_s1, m_s2;
    int unsigned m_run [CH];

    multi_debouncer #(
        .p_CH_CNT     (CH),
        .p_CNT_WIDTH  (W),
        .p_INIT_VALUE (INIT)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_in      (din),
        .o_out     (o_out),
        .o_rise    (o_rise),
        .o_fall    (o_fall),
        .o_changed (o_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_out = INIT;
        m_s1  = INIT;
        m_s2  = INIT;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
    endtask

    // One clock: model the edge, push the expectation, pop and compare 1 time unit later.
    task automatic step();
        exp_t          e;
        logic [CH-1:0] smp;
        @(posedge clk);
        e.rise = '0;
        e.fall = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
`ifdef MULTI_DEBOUNCER_SYNC_EN
            smp  = m_s2;
            m_s2 = m_s1;
            m_s1 = din;
`else
            smp = din;
`endif
            for (int k = 0; k < CH; k++) begin
                if (smp[k] != m_out[k]) begin
                    m_run[k]++;
                    if (m_run[k] == PERIOD) begin
                        m_out[k] = smp[k];
                        m_run[k] = 0;
                        if (smp[k]) e.rise[k] = 1'b1;
                        else        e.fall[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
        e.out     = m_out;
        e.changed = |(e.rise | e.fall);
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 4'b0001, 4'b0000);
        end else begin
            e = sb.pop_front();
            check("out",     o_out,  e.out);
            check("rise",    o_rise, e.rise);
            check("fall",    o_fall, e.fall);
            check("changed", {3'b000, o_changed}, {3'b000, e.changed});
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int unsigned lat;
        logic        seen;
        rst_n = 1'b0;
        din   = 4'b1111;
        model_reset();
        #1;
        check("reset_out_async", o_out, INIT);
        check("reset_strobes", o_rise | o_fall, 4'b0000);
        @(negedge clk);
        steps(10);

        // Release: all four channels rise together after the full latency.
        rst_n = 1'b1;
        steps(LAT + 2);
        din = 4'b0000;
        steps(LAT + 2);

        // Channel 0 toggling every clock never commits.
        for (int i = 0; i < 12; i++) begin
            din[0] = ~din[0];
            step();
        end
        check("toggle_ch0_stable", {3'b000, o_out[0]}, 4'b0000);
        din[0] = 1'b0;
        steps(LAT + 2);

        // Channel 1: bursts one clock short of the stable period.
        for (int r = 0; r < 6; r++) begin
            din[1] = 1'b1;
            steps(PERIOD - 1);
            din[1] = 1'b0;
            step();
        end
        check("short_bursts_ch1", {3'b000, o_out[1]}, 4'b0000);
        din[1] = 1'b1;
        steps(LAT + 2);
        check("hold_ch1_commits", {3'b000, o_out[1]}, 4'b0001);

        // Channels 2 and 3 rise together; 3 then 2 fall one clock apart.
        din[3:2] = 2'b11;
        steps(LAT + 2);
        din[3] = 1'b0;
        step();
        din[2] = 1'b0;
        steps(LAT + 2);

        // Asynchronous reset in the middle of a count on channel 0.
        din[0] = 1'b1;
        steps(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midcount_reset_async", o_out, INIT);
        model_reset();
        @(negedge clk);
        steps(2);
        rst_n = 1'b1;
        steps(LAT + 2);

        // Directed latency measurement on channel 0.
        din = 4'b0000;
        steps(LAT + 2);
        din[0] = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step();
            if (o_out[0] === 1'b1) begin
                lat  = i;
                seen = 1'b1;
            end
        end
        check("latency_edges", lat[3:0], LAT[3:0]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
